// File: rtl/axi_rd_responder.sv
// AXI4 read responder: one burst at a time, FIXED/INCR/WRAP up to 256 beats,
// fetched beat by beat from a single-cycle-latency 64-bit memory port.
module axi_rd_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] MEM_SIZE  = 32'h0800_0000
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        ARVALID,
  output logic        ARREADY,
  input  logic [31:0] ARADDR,
  input  logic [7:0]  ARLEN,
  input  logic [2:0]  ARSIZE,
  input  logic [1:0]  ARBURST,
  input  logic [2:0]  ARPROT,
  output logic        RVALID,
  input  logic        RREADY,
  output logic [63:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RLAST,
  output logic        mem_ren,
  output logic [31:0] mem_addr,
  input  logic [63:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where VALID and READY are
  // both high; RVALID, once raised, holds RDATA/RRESP/RLAST until RREADY.
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d, beat_q, beat_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic        slverr_q, slverr_d, decerr_q, decerr_d;
  logic        arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [63:0] rdata_q, rdata_d;
  logic        ren_q, ren_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] nxt_addr;
  logic        ar_bad;
  logic        unused_prot;

  function automatic logic in_range(input logic [31:0] a);
    return (a - BASE_ADDR) < MEM_SIZE;
  endfunction

  function automatic logic [31:0] adv(input logic [31:0] a, input logic [2:0] sz,
                                      input logic [1:0] b, input logic [7:0] l);
    logic [31:0] step, wl;
    step = 32'd1 << sz;
    wl   = ({24'd0, l} + 32'd1) << sz;
    case (b)
      2'd1:    return a + step;
      2'd2:    return (a & ~(wl - 32'd1)) | ((a + step) & (wl - 32'd1));
      default: return a;
    endcase
  endfunction

  assign unused_prot = ^ARPROT;
  assign nxt_addr    = adv(addr_q, size_q, burst_q, len_q);
  assign ar_bad      = (ARBURST == 2'd3) || (ARSIZE > 3'd3) ||
                       ((ARBURST == 2'd2) && !((ARLEN == 8'd1) || (ARLEN == 8'd3) ||
                                               (ARLEN == 8'd7) || (ARLEN == 8'd15)));

  // The beat address is decoded on the edge that enters FETCH, so the memory
  // strobe is registered and visible for the whole FETCH cycle.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    size_d    = size_q;
    burst_d   = burst_q;
    slverr_d  = slverr_q;
    decerr_d  = decerr_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    ren_d     = 1'b0;
    maddr_d   = maddr_q;
    case (state_q)
      IDLE: begin
        arready_d = 1'b1;
        if (ARVALID && arready_q) begin
          addr_d    = ARADDR;
          len_d     = ARLEN;
          size_d    = ARSIZE;
          burst_d   = ARBURST;
          beat_d    = 8'd0;
          slverr_d  = ar_bad;
          decerr_d  = !in_range(ARADDR);
          arready_d = 1'b0;
          if (!ar_bad && in_range(ARADDR)) begin
            ren_d   = 1'b1;
            maddr_d = ARADDR & ~32'd7;
          end
          state_d = FETCH;
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        rdata_d  = (slverr_q || decerr_q) ? 64'd0 : mem_rdata;
        rresp_d  = slverr_q ? 2'd2 : (decerr_q ? 2'd3 : 2'd0);
        rlast_d  = (beat_q == len_q);
        rvalid_d = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        if (RREADY) begin
          rvalid_d = 1'b0;
          if (rlast_q) begin
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            state_d   = IDLE;
          end else begin
            beat_d   = beat_q + 8'd1;
            addr_d   = nxt_addr;
            decerr_d = !in_range(nxt_addr);
            if (!slverr_q && in_range(nxt_addr)) begin
              ren_d   = 1'b1;
              maddr_d = nxt_addr & ~32'd7;
            end
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      addr_q    <= 32'd0;
      len_q     <= 8'd0;
      beat_q    <= 8'd0;
      size_q    <= 3'd0;
      burst_q   <= 2'd0;
      slverr_q  <= 1'b0;
      decerr_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= 2'd0;
      rdata_q   <= 64'd0;
      ren_q     <= 1'b0;
      maddr_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      slverr_q  <= slverr_d;
      decerr_q  <= decerr_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      ren_q     <= ren_d;
      maddr_q   <= maddr_d;
    end
  end

  assign ARREADY   = arready_q;
  assign RVALID    = rvalid_q;
  assign RDATA     = rdata_q;
  assign RRESP     = rresp_q;
  assign RLAST     = rlast_q;
  assign mem_ren   = ren_q;
  assign mem_addr  = maddr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_axi_rd_responder.sv
// Bench for axi_rd_responder: directed bursts plus random traffic, checked
// every cycle against a burst-level model of the expected beats.
module tb_axi_rd_responder;

  logic        ACLK, ARESETn, ARVALID, ARREADY, RVALID, RREADY, RLAST, mem_ren;
  logic [31:0] ARADDR, mem_addr;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE, ARPROT;
  logic [1:0]  ARBURST, RRESP, dbg_state;
  logic [63:0] RDATA, mem_rdata;

  int checks = 0;
  int errors = 0;

  axi_rd_responder dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARPROT(ARPROT), .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA),
    .RRESP(RRESP), .RLAST(RLAST), .mem_ren(mem_ren), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] data_of(input logic [31:0] a);
    if (a == 32'h8000_0008) return 64'h1122_3344_5566_7788;
    return {a ^ 32'h5A5A_1234, ~a};
  endfunction

  // memory: data valid only in the cycle after the strobe, garbage otherwise
  always @(posedge ACLK)
    mem_rdata <= mem_ren ? data_of(mem_addr) : {$urandom, $urandom};

  // RREADY driver
  int   rr_mode = 0;
  int   pidx = 0;
  logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  initial begin
    RREADY = 1'b0;
    forever begin
      @(posedge ACLK); #2;
      case (rr_mode)
        0: RREADY = 1'b1;
        1: RREADY = 1'($urandom_range(0, 1));
        default: begin RREADY = pat[pidx]; pidx = (pidx + 1) % 4; end
      endcase
    end
  end

  // model / scoreboard
  logic [63:0] exp_q[$];
  logic [1:0]  exp_resp_q[$];
  logic        exp_last_q[$];
  logic [31:0] exp_maddr_q[$];
  logic [63:0] data_log[$];
  logic [1:0]  resp_log[$];
  logic        last_log[$];
  logic [31:0] ren_log[$];
  logic        busy = 1'b0;
  logic        rst_edge = 1'b1;
  logic        prev_rvalid = 1'b0, prev_ren = 1'b0;
  logic        was_last;
  int          edge_cnt = 0;
  int          last_hs = 0;

  always @(posedge ACLK) begin
    rst_edge <= !ARESETn;
    edge_cnt <= edge_cnt + 1;
  end

  task automatic model_ar(input logic [31:0] a0, input logic [7:0] l,
                          input logic [2:0] s, input logic [1:0] b);
    logic [31:0] a, step, wl, base;
    logic        bad;
    bad  = (b == 2'd3) || (s > 3'd3) ||
           (b == 2'd2 && !(l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15));
    a    = a0;
    step = 32'd1 << s;
    wl   = (32'(l) + 32'd1) * step;
    for (int i = 0; i <= int'(l); i++) begin
      if (bad) begin
        exp_q.push_back(64'd0); exp_resp_q.push_back(2'd2);
      end else if (a >= 32'h8000_0000 && a < 32'h8800_0000) begin
        exp_q.push_back(data_of({a[31:3], 3'b000})); exp_resp_q.push_back(2'd0);
        exp_maddr_q.push_back({a[31:3], 3'b000});
      end else begin
        exp_q.push_back(64'd0); exp_resp_q.push_back(2'd3);
      end
      exp_last_q.push_back(i == int'(l));
      if (b == 2'd1) a = a + step;
      else if (b == 2'd2) begin
        base = a - (a % wl);
        a    = base + ((a - base + step) % wl);
      end
    end
  endtask

  always @(negedge ACLK) begin
    if (rst_edge) begin
      chk("rst_arready", ARREADY, 0); chk("rst_rvalid", RVALID, 0);
      chk("rst_rlast", RLAST, 0);     chk("rst_rresp", RRESP, 0);
      chk("rst_rdata", RDATA, 0);     chk("rst_ren", mem_ren, 0);
      chk("rst_maddr", mem_addr, 0);  chk("rst_state", dbg_state, 0);
      exp_q.delete(); exp_resp_q.delete(); exp_last_q.delete(); exp_maddr_q.delete();
      busy = 1'b0; prev_rvalid = 1'b0; prev_ren = 1'b0;
    end else begin
      chk("arready", ARREADY, !busy);
      if (mem_ren) begin
        chk("ren_time", edge_cnt, last_hs);
        chk("ren_pulse", prev_ren, 0);
        if (exp_maddr_q.size() == 0) chk("ren_spurious", 1, 0);
        else chk("mem_addr", mem_addr, exp_maddr_q.pop_front());
        ren_log.push_back(mem_addr);
      end
      if (RVALID) begin
        if (!prev_rvalid) chk("rvalid_time", edge_cnt, last_hs + 2);
        if (exp_q.size() == 0) chk("rvalid_spurious", 1, 0);
        else begin
          chk("rdata", RDATA, exp_q[0]);
          chk("rresp", RRESP, exp_resp_q[0]);
          chk("rlast", RLAST, exp_last_q[0]);
          if (RREADY && ARESETn) begin
            data_log.push_back(RDATA); resp_log.push_back(RRESP); last_log.push_back(RLAST);
            void'(exp_q.pop_front()); void'(exp_resp_q.pop_front());
            was_last = exp_last_q.pop_front();
            if (was_last) busy = 1'b0;
            last_hs = edge_cnt + 1;
          end
        end
      end else chk("rlast_idle", RLAST, 0);
      if (ARVALID && ARREADY && ARESETn) begin
        model_ar(ARADDR, ARLEN, ARSIZE, ARBURST);
        busy    = 1'b1;
        last_hs = edge_cnt + 1;
      end
      prev_rvalid = RVALID;
      prev_ren    = mem_ren;
    end
  end

  // driver tasks
  task automatic issue(input logic [31:0] a, input logic [7:0] l,
                       input logic [2:0] s, input logic [1:0] b);
    logic ok;
    ok = 1'b0;
    @(posedge ACLK); #2;
    ARVALID = 1'b1; ARADDR = a; ARLEN = l; ARSIZE = s; ARBURST = b;
    ARPROT = 3'($urandom_range(0, 7));
    for (int i = 0; i < 200; i++) begin
      @(negedge ACLK);
      if (ARREADY) begin ok = 1'b1; break; end
    end
    if (!ok) chk("ar_timeout", 0, 1);
    @(posedge ACLK); #2;
    ARVALID = 1'b0;
  endtask

  task automatic wait_done();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge ACLK);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) chk("burst_timeout", 0, 1);
  endtask

  task automatic clear_logs();
    data_log.delete(); resp_log.delete(); last_log.delete(); ren_log.delete();
  endtask

  function automatic logic [31:0] ren_at(input int i);
    return (i < ren_log.size()) ? ren_log[i] : 32'hxxxx_xxxx;
  endfunction

  logic [31:0] incr_exp[4] = '{32'h8000_0000, 32'h8000_0008, 32'h8000_0010, 32'h8000_0018};
  logic [31:0] wrap_exp[4] = '{32'h8000_0010, 32'h8000_0018, 32'h8000_0000, 32'h8000_0008};
  logic [31:0] ra;
  logic [7:0]  rl;
  int          hs_ok;

  initial begin
    ARESETn = 1'b0; ARVALID = 1'b0; ARADDR = '0; ARLEN = '0; ARSIZE = '0;
    ARBURST = '0; ARPROT = '0;
    repeat (3) @(posedge ACLK);
    #2 ARESETn = 1'b1;
    repeat (2) @(posedge ACLK);

    // single beat
    clear_logs(); rr_mode = 0;
    issue(32'h8000_0008, 8'd0, 3'd3, 2'd1); wait_done();
    chk("single_n", data_log.size(), 1);
    chk("single_data", data_log.size() > 0 ? data_log[0] : 64'hx, 64'h1122_3344_5566_7788);
    chk("single_last", last_log.size() > 0 ? last_log[0] : 1'bx, 1'b1);

    // INCR 4 beats with stalling RREADY
    clear_logs(); rr_mode = 2;
    issue(32'h8000_0000, 8'd3, 3'd3, 2'd1); wait_done();
    chk("incr_n", ren_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("incr_addr", ren_at(i), incr_exp[i]);
    for (int i = 0; i < 4; i++) chk("incr_last", i < last_log.size() ? last_log[i] : 1'bx, i == 3);

    // WRAP 4 beats
    clear_logs(); rr_mode = 0;
    issue(32'h8000_0010, 8'd3, 3'd3, 2'd2); wait_done();
    for (int i = 0; i < 4; i++) chk("wrap_addr", ren_at(i), wrap_exp[i]);

    // range crossing
    clear_logs();
    issue(32'h87FF_FFF8, 8'd1, 3'd3, 2'd1); wait_done();
    chk("cross_ren_n", ren_log.size(), 1);
    chk("cross_r0", resp_log.size() > 1 ? resp_log[0] : 2'bx, 2'd0);
    chk("cross_r1", resp_log.size() > 1 ? resp_log[1] : 2'bx, 2'd3);
    chk("cross_d1", data_log.size() > 1 ? data_log[1] : 64'hx, 64'd0);

    // burst errors
    clear_logs();
    issue(32'h8000_0100, 8'd2, 3'd3, 2'd3); wait_done();
    issue(32'h8000_0100, 8'd2, 3'd3, 2'd2); wait_done();
    issue(32'h8000_0100, 8'd0, 3'd4, 2'd1); wait_done();
    chk("err_n", resp_log.size(), 7);
    chk("err_ren_n", ren_log.size(), 0);
    for (int i = 0; i < 7; i++) chk("err_resp", i < resp_log.size() ? resp_log[i] : 2'bx, 2'd2);

    // reset mid-burst
    clear_logs();
    issue(32'h8000_0200, 8'd7, 3'd3, 2'd1);
    hs_ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge ACLK);
      if (data_log.size() >= 3) begin hs_ok = 1; break; end
    end
    chk("midrst_reach", hs_ok, 1);
    @(posedge ACLK); #2 ARESETn = 1'b0;
    repeat (2) @(posedge ACLK);
    #2 ARESETn = 1'b1;
    @(posedge ACLK);
    clear_logs();
    issue(32'h8000_0008, 8'd0, 3'd3, 2'd1); wait_done();
    chk("post_rst_data", data_log.size() > 0 ? data_log[0] : 64'hx, 64'h1122_3344_5566_7788);

    // random traffic
    for (int n = 0; n < 40; n++) begin
      rr_mode = int'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: ra = 32'h8000_0000 + ($urandom_range(0, 1023) << 3) + $urandom_range(0, 7);
        1: ra = 32'h8800_0000 - ($urandom_range(1, 40) << 3);
        2: ra = 32'h7FFF_FF80 + $urandom_range(0, 127);
        default: ra = $urandom;
      endcase
      rl = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      issue(ra, rl, 3'($urandom_range(0, 4)), 2'($urandom_range(0, 3)));
      wait_done();
    end

    repeat (3) @(negedge ACLK);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
